cnt_sequencer: RTL
==================

# cnt_sequencer

Sequencing controller for a 4-bit loadable up/down counter with active-high load/inc/dec strobes, registered count feedback, and one-cycle update latency. On a start handshake it loads a start value, then steps the counter between programmable `lo`/`hi` bounds at a prescaled rate. It supports up, down or bounce (ping-pong) sweeps for a programmed number of passes, then pulses `done`. It sits between the board-level control logic and the counter instance, which it owns exclusively.

## Interface
- `W`, 4, counter width.
- `PW`, 8, prescale field width.

- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `start`  in  1  begin sequence; sampled only in IDLE.
- `abort`  in  1  cancel sequence; effective in any non-IDLE state.
- `mode`  in  2  sweep mode: 0 = up, 1 = down, 2 = bounce, 3 = reserved.
- `lo`  in  W  lower bound.
- `hi`  in  W  upper bound.
- `passes`  in  4  number of passes; 0 is treated as 1.
- `prescale`  in  PW  step interval is `prescale+1` cycles.
- `cnt_q`  in  W  counter output feedback.
- `cnt_load`  out  1  counter load strobe.
- `cnt_inc`  out  1  counter increment strobe.
- `cnt_dec`  out  1  counter decrement strobe.
- `cnt_din`  out  W  counter load value.
- `busy`  out  1  high in LOAD and RUN.
- `done`  out  1  one-cycle pulse on normal completion.
- `err`  out  1  one-cycle pulse on rejected start.

## Operation
- **States:** IDLE, LOAD, RUN, DONE.
- **IDLE, start sampled high:**
  - If `mode==3` or `lo>hi`: `err` is 1 the next cycle and the state stays IDLE.
  - Otherwise: latch `mode`, `lo`, `hi`, `passes`, `prescale`; go to LOAD.
  - Config inputs are ignored after latching.
- **LOAD (1 cycle):**
  - `cnt_load`=1.
  - `cnt_din` = `lo` for up/bounce, `hi` for down.
  - Direction register is set to up for modes 0/2, down for mode 1.
  - Prescale down-counter is loaded with `prescale`.
- **RUN, tick:** asserted when the prescale counter is 0; the counter reloads `prescale` on each tick. No strobes are issued on non-tick cycles.
- **Endpoint:** `cnt_q==hi` when direction is up; `cnt_q==lo` when direction is down.
- **Tick, not at endpoint:** `cnt_inc` or `cnt_dec` per direction.
- **Tick, at endpoint:** the pass completes and `passes_left` decrements.
  - Last pass: go to DONE with no strobe.
  - Else, mode 0/1: `cnt_load` with `cnt_din` = start value, and direction is unchanged.
  - Else, bounce: flip direction and issue the strobe in the new direction in the same cycle. If `lo==hi`, no strobe is issued.
- **DONE (1 cycle):** `done`=1, `busy`=0, then IDLE.
- **abort high in LOAD/RUN/DONE:**
  - All strobes are forced to 0 combinationally in that cycle.
  - State is IDLE at the next edge.
  - `done` does not pulse.
  - The counter keeps its value.
- **Strobe exclusivity:** at most one of `cnt_load`/`cnt_inc`/`cnt_dec` is high in any cycle.
- **Register widths:** `passes_left` is 4 bits. Bound compares are W-bit unsigned. The counter is never commanded past `hi` or below `lo`, so it never wraps.

## Timing
- **Reset values:** state IDLE; `cnt_load`, `cnt_inc`, `cnt_dec`, `busy`, `done`, `err` = 0; `cnt_din`=0; all internal registers 0.
- **Output paths:** strobes are decoded from registered state, the registered tick, and `cnt_q`. `cnt_q` and `abort` are the only input-to-output combinational paths.
- **Counter latency:** the counter updates at the edge ending a strobe cycle, so the new `cnt_q` is evaluated on the next tick. The minimum interval (prescale=0) is one strobe per cycle.
- **Latency:**
  - start edge → LOAD: 1 cycle.
  - First RUN cycle: tick fires after `prescale` further cycles.
  - Single up pass with prescale=0: `done` is high in cycle `hi-lo+3` after the start edge.
- **start during busy/DONE:** ignored.

## Structure
- **Package `cnt_seq_pkg`:**
  - State enum (IDLE, LOAD, RUN, DONE).
  - Mode encodings (`MODE_UP`=0, `MODE_DOWN`=1, `MODE_BOUNCE`=2).
  - Default `W`/`PW`.
- **Sub-module `tick_gen`:** PW-bit reloadable down-counter. Inputs: `clk`, `reset_n`, `clear` (load), `en`, `reload_val`. Output: `tick`.
- **Bench:** instantiates a behavioural 4-bit load/inc/dec counter model as the DUT load.

## Test plan
- **Single up pass:** mode 0, lo=2, hi=5, passes=1, prescale=0 → load din=2, then 3 `cnt_inc` in consecutive cycles, `done` in cycle 6 after start, final `cnt_q`=5.
- **Bounce:** mode 2, lo=1, hi=3, passes=2, prescale=0 → strobes load(1), inc, inc, dec, dec, then `done`; final `cnt_q`=1.
- **Repeated down passes with prescale:** mode 1, lo=0, hi=15, passes=2, prescale=3 → strobes spaced 4 cycles apart, `cnt_load` with din=15 at the first endpoint, one `done`, no wrap below 0.
- **Rejected start:** lo=7, hi=4 → `err` 1 cycle, no strobes, `busy`=0. Repeat with mode 3 → same response.
- **Abort and busy start:** abort mid-RUN at `cnt_q`=4 → no strobe that cycle, IDLE next, no `done`, `cnt_q` stays 4. A start issued while busy has no effect.
- **Reset and degenerate range:** `reset_n` low mid-RUN → all outputs 0 immediately, then IDLE. lo=hi=9, passes=3, mode 2 → load 9, zero inc/dec, `done` after 3 ticks.

Source files
------------

// File: rtl/cnt_sequencer_pkg.sv
// Shared types and constants for the counter sequencer: FSM states,
// sweep-mode encodings and default widths.
package cnt_seq_pkg;

  localparam int DEF_W  = 4;
  localparam int DEF_PW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] MODE_UP     = 2'd0;
  localparam logic [1:0] MODE_DOWN   = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_RSVD   = 2'd3;

endpackage

// File: rtl/cnt_sequencer_if.sv
// Bus between the sequencer (master) and the loadable up/down counter (slave).
interface cnt_sequencer_if
  import cnt_seq_pkg::*;
#(
  parameter int W = DEF_W
);

  logic         cnt_load;
  logic         cnt_inc;
  logic         cnt_dec;
  logic [W-1:0] cnt_din;
  logic [W-1:0] cnt_q;

  modport master (
    output cnt_load,
    output cnt_inc,
    output cnt_dec,
    output cnt_din,
    input  cnt_q
  );

  modport slave (
    input  cnt_load,
    input  cnt_inc,
    input  cnt_dec,
    input  cnt_din,
    output cnt_q
  );

endinterface

// File: rtl/cnt_sequencer_tick_gen.sv
// Reloadable down-counter; tick is high whenever the count sits at zero and
// the count wraps back to reload_val on that cycle when enabled.
module tick_gen
  import cnt_seq_pkg::*;
#(
  parameter int PW = DEF_PW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          en,
  input  logic [PW-1:0] reload_val,
  output logic          tick
);

  logic [PW-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= reload_val;
    end else if (en) begin
      count <= (count == '0) ? reload_val : count - 1'b1;
    end
  end

  assign tick = (count == '0);

endmodule

// File: rtl/cnt_sequencer.sv
// Sequencing controller that loads the owned counter and sweeps it between
// lo/hi bounds (up, down or bounce) for a number of passes at a prescaled rate.
module cnt_sequencer
  import cnt_seq_pkg::*;
#(
  parameter int W  = DEF_W,
  parameter int PW = DEF_PW
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            abort,
  input  logic [1:0]      mode,
  input  logic [W-1:0]    lo,
  input  logic [W-1:0]    hi,
  input  logic [3:0]      passes,
  input  logic [PW-1:0]   prescale,
  cnt_sequencer_if.master cnt_bus,
  output logic            busy,
  output logic            done,
  output logic            err
);

  state_t        state;
  logic [1:0]    mode_q;
  logic [W-1:0]  lo_q;
  logic [W-1:0]  hi_q;
  logic [W-1:0]  start_val_q;
  logic [3:0]    passes_left;
  logic [PW-1:0] prescale_q;
  logic          dir_up;
  logic          err_q;
  logic          tick;
  logic          at_end;
  logic          last_pass;
  logic          load_raw;
  logic          inc_raw;
  logic          dec_raw;

  tick_gen #(.PW(PW)) u_tick_gen (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (state == LOAD),
    .en         (state == RUN),
    .reload_val (prescale_q),
    .tick       (tick)
  );

  assign at_end    = dir_up ? (cnt_bus.cnt_q == hi_q) : (cnt_bus.cnt_q == lo_q);
  assign last_pass = (passes_left <= 4'd1);

  // At a bounce endpoint the strobe already points the new way, so the
  // turnaround costs no extra tick; a single-value range has nowhere to go.
  always_comb begin
    load_raw = 1'b0;
    inc_raw  = 1'b0;
    dec_raw  = 1'b0;
    case (state)
      LOAD: load_raw = 1'b1;
      RUN: begin
        if (tick) begin
          if (!at_end) begin
            inc_raw = dir_up;
            dec_raw = !dir_up;
          end else if (!last_pass) begin
            if (mode_q == MODE_BOUNCE) begin
              if (lo_q != hi_q) begin
                inc_raw = !dir_up;
                dec_raw = dir_up;
              end
            end else begin
              load_raw = 1'b1;
            end
          end
        end
      end
      default: ;
    endcase
  end

  assign cnt_bus.cnt_load = load_raw & ~abort;
  assign cnt_bus.cnt_inc  = inc_raw & ~abort;
  assign cnt_bus.cnt_dec  = dec_raw & ~abort;
  assign cnt_bus.cnt_din  = start_val_q;

  assign busy = (state == LOAD) || (state == RUN);
  assign done = (state == DONE) && !abort;
  assign err  = err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      mode_q      <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      start_val_q <= '0;
      passes_left <= '0;
      prescale_q  <= '0;
      dir_up      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (mode == MODE_RSVD || lo > hi) begin
              err_q <= 1'b1;
            end else begin
              mode_q      <= mode;
              lo_q        <= lo;
              hi_q        <= hi;
              start_val_q <= (mode == MODE_DOWN) ? hi : lo;
              passes_left <= (passes == 4'd0) ? 4'd1 : passes;
              prescale_q  <= prescale;
              state       <= LOAD;
            end
          end
        end
        LOAD: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            dir_up <= (mode_q != MODE_DOWN);
            state  <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
          end else if (tick && at_end) begin
            passes_left <= passes_left - 4'd1;
            if (last_pass) begin
              state <= DONE;
            end else if (mode_q == MODE_BOUNCE) begin
              dir_up <= !dir_up;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
